// File: rtl/trng_reseed_ctrl.sv
// trng_reseed_ctrl: schedules CSPRNG reseeds after INTERVAL output blocks; optional BLOCK_CTR/RESEED_CTR readout under TRNG_RESEED_STATS_EN.
// Latency: register reads are combinational; csprng_reseed rises one cycle after entropy_ready is seen in WAIT_ENTROPY.
// Backpressure: the reseed request is held until reseed_ack or TIMEOUT expiry; block_done is never stalled.
module trng_reseed_ctrl #(
    parameter logic [31:0] DEFAULT_INTERVAL = 32'h0010_0000,
    parameter logic [31:0] DEFAULT_TIMEOUT  = 32'h0000_ffff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        error,
    input  logic        block_done,
    input  logic        entropy_ready,
    output logic        csprng_reseed,
    input  logic        reseed_ack,
    input  logic        csprng_error,
    output logic        security_error
);
    localparam logic [7:0] ADDR_CTRL       = 8'h08;
    localparam logic [7:0] ADDR_STATUS     = 8'h09;
    localparam logic [7:0] ADDR_INTERVAL   = 8'h10;
    localparam logic [7:0] ADDR_TIMEOUT    = 8'h11;
`ifdef TRNG_RESEED_STATS_EN
    localparam logic [7:0] ADDR_BLOCK_CTR  = 8'h20;
    localparam logic [7:0] ADDR_RESEED_CTR = 8'h21;
`endif

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        COUNT        = 3'd1,
        WAIT_ENTROPY = 3'd2,
        RESEED       = 3'd3,
        ERROR        = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [2:0]  state_code;
    logic        enable, force_reseed, clear_error;
    logic [31:0] interval, timeout, block_ctr, timeout_ctr;
    logic [31:0] block_ctr_inc, timeout_ctr_inc, interval_eff, block_ctr_next;
    logic        interval_hit, active;
    logic        wr_ctrl, wr_interval, wr_timeout;
    logic [31:0] rd_mux;
    logic        addr_ok, addr_ro;

    assign state_code      = state;
    assign block_ctr_inc   = (block_ctr == 32'hffff_ffff) ? block_ctr : block_ctr + 32'd1;
    assign timeout_ctr_inc = (timeout_ctr == 32'hffff_ffff) ? timeout_ctr : timeout_ctr + 32'd1;
    assign interval_eff    = (interval == 32'd0) ? 32'd1 : interval;
    assign interval_hit    = block_done && (block_ctr_inc >= interval_eff);
    assign active          = (state == COUNT) || (state == WAIT_ENTROPY) || (state == RESEED);

    // Priority inside active states: csprng_error, then loss of enable, then normal progress.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable) state_next = COUNT;
            COUNT: begin
                if (csprng_error)                      state_next = ERROR;
                else if (!enable)                      state_next = IDLE;
                else if (force_reseed || interval_hit) state_next = WAIT_ENTROPY;
            end
            WAIT_ENTROPY: begin
                if (csprng_error)       state_next = ERROR;
                else if (!enable)       state_next = IDLE;
                else if (entropy_ready) state_next = RESEED;
            end
            RESEED: begin
                if (csprng_error)                state_next = ERROR;
                else if (!enable)                state_next = IDLE;
                else if (reseed_ack)             state_next = COUNT;
                else if (timeout_ctr == timeout) state_next = ERROR;
            end
            ERROR: if (clear_error) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        block_ctr_next = block_ctr;
        if (state_next == IDLE)
            block_ctr_next = '0;
        else if (state == COUNT && state_next == WAIT_ENTROPY)
            block_ctr_next = '0;
        else if (block_done && active)
            block_ctr_next = block_ctr_inc;
    end

    assign wr_ctrl     = cs && we && (address == ADDR_CTRL);
    assign wr_interval = cs && we && (address == ADDR_INTERVAL);
    assign wr_timeout  = cs && we && (address == ADDR_TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            enable         <= 1'b0;
            force_reseed   <= 1'b0;
            clear_error    <= 1'b0;
            csprng_reseed  <= 1'b0;
            security_error <= 1'b0;
            block_ctr      <= '0;
            timeout_ctr    <= '0;
            interval       <= DEFAULT_INTERVAL;
            timeout        <= DEFAULT_TIMEOUT;
        end else begin
            state          <= state_next;
            block_ctr      <= block_ctr_next;
            csprng_reseed  <= (state_next == RESEED);
            security_error <= (state_next == ERROR);
            force_reseed   <= wr_ctrl && write_data[1];
            clear_error    <= wr_ctrl && write_data[2];
            if (state == WAIT_ENTROPY && state_next == RESEED)
                timeout_ctr <= '0;
            else if (state == RESEED)
                timeout_ctr <= timeout_ctr_inc;
            // Leaving ERROR drops enable even if software rewrites CTRL in the same cycle.
            if (state == ERROR && state_next == IDLE)
                enable <= 1'b0;
            else if (wr_ctrl)
                enable <= write_data[0];
            if (wr_interval) interval <= write_data;
            if (wr_timeout)  timeout  <= write_data;
        end
    end

`ifdef TRNG_RESEED_STATS_EN
    logic [31:0] reseed_ctr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            reseed_ctr <= '0;
        else if (state == RESEED && state_next == COUNT && reseed_ctr != 32'hffff_ffff)
            reseed_ctr <= reseed_ctr + 32'd1;
    end
`endif

    always_comb begin
        rd_mux  = '0;
        addr_ok = 1'b1;
        addr_ro = 1'b0;
        case (address)
            ADDR_CTRL:     rd_mux = {29'b0, clear_error, force_reseed, enable};
            ADDR_STATUS: begin
                rd_mux  = {27'b0, security_error, csprng_reseed, state_code};
                addr_ro = 1'b1;
            end
            ADDR_INTERVAL: rd_mux = interval;
            ADDR_TIMEOUT:  rd_mux = timeout;
`ifdef TRNG_RESEED_STATS_EN
            ADDR_BLOCK_CTR: begin
                rd_mux  = block_ctr;
                addr_ro = 1'b1;
            end
            ADDR_RESEED_CTR: begin
                rd_mux  = reseed_ctr;
                addr_ro = 1'b1;
            end
`endif
            default:       addr_ok = 1'b0;
        endcase
    end

    assign error     = cs && (!addr_ok || (we && addr_ro));
    assign read_data = (cs && !we && !error) ? rd_mux : 32'd0;
endmodule

// File: tb/tb_trng_reseed_ctrl.sv
// Directed bench for trng_reseed_ctrl: register map, reseed scheduling, timeout and error paths.
module tb_trng_reseed_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  address = 8'h00;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        error;
    logic        block_done = 1'b0;
    logic        entropy_ready = 1'b0;
    logic        csprng_reseed;
    logic        reseed_ack = 1'b0;
    logic        csprng_error = 1'b0;
    logic        security_error;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] d;
    logic        e;

    trng_reseed_ctrl dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data), .error(error),
        .block_done(block_done), .entropy_ready(entropy_ready),
        .csprng_reseed(csprng_reseed), .reseed_ack(reseed_ack),
        .csprng_error(csprng_error), .security_error(security_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [7:0] a, output logic [31:0] rd, output logic er);
        cs = 1'b1; we = 1'b0; address = a;
        #1;
        rd = read_data; er = error;
        cs = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] wd, output logic er);
        cs = 1'b1; we = 1'b1; address = a; write_data = wd;
        #1;
        er = error;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic pulse_block(input int n);
        for (int i = 0; i < n; i++) begin
            block_done = 1'b1;
            tick();
        end
        block_done = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        vectors++; if (csprng_reseed !== 1'b0) begin miscompares++; $display("FAIL reset_reseed: got %b want 0", csprng_reseed); end
        vectors++; if (security_error !== 1'b0) begin miscompares++; $display("FAIL reset_secerr: got %b want 0", security_error); end
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h want 0", d); end
        peek(8'h10, d, e);
        vectors++; if (d !== 32'h0010_0000) begin miscompares++; $display("FAIL reset_interval: got %h want 00100000", d); end
        peek(8'h11, d, e);
        vectors++; if (d !== 32'h0000_ffff) begin miscompares++; $display("FAIL reset_timeout: got %h want 0000ffff", d); end
        peek(8'h08, d, e);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h want 0", d); end
        reset = 1'b0;
        tick();
        address = 8'h10; we = 1'b0; cs = 1'b0;
        #1;
        vectors++; if (read_data !== 32'h0 || error !== 1'b0) begin miscompares++; $display("FAIL cs_low_read: got data %h err %b want 0/0", read_data, error); end
    endtask

    task automatic test_regs();
        wr(8'h09, 32'hffff_ffff, e);
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL wr_status_err: got %b want 1", e); end
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL status_unchanged: got %h want 0", d); end
        peek(8'h08, d, e);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL ctrl_unchanged: got %h want 0", d); end
        wr(8'h10, 32'h0000_1234, e);
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL wr_interval_err: got %b want 0", e); end
        peek(8'h10, d, e);
        vectors++; if (d !== 32'h0000_1234 || e !== 1'b0) begin miscompares++; $display("FAIL rd_interval: got %h err %b want 00001234/0", d, e); end
        peek(8'h30, d, e);
        vectors++; if (d !== 32'h0 || e !== 1'b1) begin miscompares++; $display("FAIL rd_undef: got %h err %b want 0/1", d, e); end
        wr(8'h30, 32'h5, e);
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL wr_undef_err: got %b want 1", e); end
        peek(8'h20, d, e);
`ifdef TRNG_RESEED_STATS_EN
        vectors++; if (d !== 32'h0 || e !== 1'b0) begin miscompares++; $display("FAIL rd_block_ctr: got %h err %b want 0/0", d, e); end
`else
        vectors++; if (d !== 32'h0 || e !== 1'b1) begin miscompares++; $display("FAIL rd_stats_absent: got %h err %b want 0/1", d, e); end
`endif
        wr(8'h10, 32'd4, e);
    endtask

    task automatic test_basic_reseed();
        entropy_ready = 1'b1;
        wr(8'h08, 32'h1, e);
        tick();
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL basic_count: got %h want 1", d); end
        pulse_block(4);
        vectors++; if (csprng_reseed !== 1'b0) begin miscompares++; $display("FAIL basic_req_early: got %b want 0", csprng_reseed); end
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL basic_wait: got %h want 2", d); end
        tick();
        vectors++; if (csprng_reseed !== 1'b1) begin miscompares++; $display("FAIL basic_req: got %b want 1", csprng_reseed); end
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h0b) begin miscompares++; $display("FAIL basic_reseed_status: got %h want 0b", d); end
        reseed_ack = 1'b1;
        tick();
        reseed_ack = 1'b0;
        vectors++; if (csprng_reseed !== 1'b0) begin miscompares++; $display("FAIL basic_ack_drop: got %b want 0", csprng_reseed); end
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL basic_back_count: got %h want 1", d); end
    endtask

    task automatic test_timeout();
        wr(8'h11, 32'd10, e);
        wr(8'h08, 32'h3, e);
        tick();
        tick();
        vectors++; if (csprng_reseed !== 1'b1) begin miscompares++; $display("FAIL to_req: got %b want 1", csprng_reseed); end
        repeat (10) tick();
        vectors++; if (csprng_reseed !== 1'b1 || security_error !== 1'b0) begin miscompares++; $display("FAIL to_early: got req %b sec %b want 1/0", csprng_reseed, security_error); end
        tick();
        vectors++; if (csprng_reseed !== 1'b0 || security_error !== 1'b1) begin miscompares++; $display("FAIL to_error: got req %b sec %b want 0/1", csprng_reseed, security_error); end
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h14) begin miscompares++; $display("FAIL to_status: got %h want 14", d); end
        repeat (5) tick();
        vectors++; if (security_error !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got %b want 1", security_error); end
        wr(8'h08, 32'h5, e);
        tick();
        vectors++; if (security_error !== 1'b0) begin miscompares++; $display("FAIL to_clear: got %b want 0", security_error); end
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL to_status_clear: got %h want 0", d); end
        peek(8'h08, d, e);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL to_enable_fsm_wins: got %h want 0", d); end
    endtask

    task automatic test_error_with_ack();
        wr(8'h08, 32'h1, e);
        tick();
        wr(8'h08, 32'h3, e);
        tick();
        tick();
        vectors++; if (csprng_reseed !== 1'b1) begin miscompares++; $display("FAIL ea_req: got %b want 1", csprng_reseed); end
        reseed_ack = 1'b1; csprng_error = 1'b1;
        tick();
        reseed_ack = 1'b0; csprng_error = 1'b0;
        vectors++; if (security_error !== 1'b1 || csprng_reseed !== 1'b0) begin miscompares++; $display("FAIL ea_error: got sec %b req %b want 1/0", security_error, csprng_reseed); end
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h14) begin miscompares++; $display("FAIL ea_status: got %h want 14", d); end
        wr(8'h08, 32'h4, e);
        tick();
        vectors++; if (security_error !== 1'b0) begin miscompares++; $display("FAIL ea_clear: got %b want 0", security_error); end
    endtask

    task automatic test_entropy_wait();
        entropy_ready = 1'b0;
        wr(8'h08, 32'h1, e);
        tick();
        wr(8'h08, 32'h3, e);
        tick();
        repeat (100) tick();
        vectors++; if (csprng_reseed !== 1'b0 || security_error !== 1'b0) begin miscompares++; $display("FAIL ew_idle: got req %b sec %b want 0/0", csprng_reseed, security_error); end
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL ew_status: got %h want 2", d); end
        entropy_ready = 1'b1;
        tick();
        vectors++; if (csprng_reseed !== 1'b1) begin miscompares++; $display("FAIL ew_req: got %b want 1", csprng_reseed); end
        reseed_ack = 1'b1;
        tick();
        reseed_ack = 1'b0;
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL ew_done: got %h want 1", d); end
    endtask

    task automatic test_force_with_block();
        pulse_block(2);
        wr(8'h08, 32'h3, e);
        block_done = 1'b1;
        tick();
        block_done = 1'b0;
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL fb_wait: got %h want 2", d); end
`ifdef TRNG_RESEED_STATS_EN
        peek(8'h20, d, e);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL fb_block_ctr: got %h want 0", d); end
`endif
        tick();
        reseed_ack = 1'b1;
        tick();
        reseed_ack = 1'b0;
        pulse_block(3);
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL fb_ctr_cleared: got %h want 1", d); end
        pulse_block(1);
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL fb_interval: got %h want 2", d); end
        tick();
        wr(8'h08, 32'h0, e);
        vectors++; if (csprng_reseed !== 1'b1) begin miscompares++; $display("FAIL dis_req_held: got %b want 1", csprng_reseed); end
        tick();
        vectors++; if (csprng_reseed !== 1'b0) begin miscompares++; $display("FAIL dis_req_drop: got %b want 0", csprng_reseed); end
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL dis_idle: got %h want 0", d); end
    endtask

    task automatic test_interval_shrink();
        entropy_ready = 1'b0;
        wr(8'h08, 32'h1, e);
        tick();
        pulse_block(3);
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL sh_count: got %h want 1", d); end
        wr(8'h10, 32'd2, e);
        pulse_block(1);
        peek(8'h09, d, e);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL sh_reseed: got %h want 2", d); end
        wr(8'h08, 32'h0, e);
        tick();
    endtask

    task automatic test_stats();
        peek(8'h21, d, e);
`ifdef TRNG_RESEED_STATS_EN
        vectors++; if (d !== 32'd3 || e !== 1'b0) begin miscompares++; $display("FAIL reseed_ctr: got %h err %b want 3/0", d, e); end
`else
        vectors++; if (d !== 32'd0 || e !== 1'b1) begin miscompares++; $display("FAIL reseed_ctr_absent: got %h err %b want 0/1", d, e); end
`endif
    endtask

    initial begin
        test_reset();
        test_regs();
        test_basic_reseed();
        test_timeout();
        test_error_with_ack();
        test_entropy_wait();
        test_force_with_block();
        test_interval_shrink();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
